// File: rtl/fb_arbiter_if.sv
// rtl/fb_arbiter_if.sv - scan-out, draw-command and framebuffer RAM signal bundle for fb_arbiter
interface fb_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;
    logic              scan_overrun;

    logic              draw_valid;
    logic              draw_ready;
    logic              draw_we;
    logic [ADDR_W-1:0] draw_addr;
    logic [DATA_W-1:0] draw_wdata;
    logic              draw_rvalid;
    logic [DATA_W-1:0] draw_rdata;
    logic              draw_busy;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  scan_req, scan_addr, draw_valid, draw_we, draw_addr, draw_wdata, mem_rdata,
        output scan_valid, scan_data, scan_overrun, draw_ready, draw_rvalid, draw_rdata,
               draw_busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output scan_req, scan_addr, draw_valid, draw_we, draw_addr, draw_wdata, mem_rdata,
        input  scan_valid, scan_data, scan_overrun, draw_ready, draw_rvalid, draw_rdata,
               draw_busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer arbiter: scan-out reads win, draw commands queue in a FIFO
module fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    fb_arbiter_if.slave bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push, pop;

    logic               head_we;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;

    logic               scan_req_q;
    logic               iss_valid, iss_we, iss_draw;
    logic [ADDR_W-1:0]  iss_addr;
    logic [DATA_W-1:0]  iss_wdata;
    logic               tag1_valid, tag1_draw;
    logic               tag2_valid, tag2_draw;

    assign {head_we, head_addr, head_wdata} = fifo_mem[rd_ptr];

    assign bus.draw_ready = !rst && (count != FULL_COUNT);
    assign push = bus.draw_valid && bus.draw_ready;
    // Pop decision uses the pre-edge count, so a command pushed this edge cannot issue until the next.
    assign pop  = !bus.scan_req && (count != '0);

    always_ff @(posedge CLK100MHZ) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.draw_we, bus.draw_addr, bus.draw_wdata};
        end
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue stage: the arbitration winner is latched here, one edge ahead of the RAM port.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            scan_req_q       <= 1'b0;
            bus.scan_overrun <= 1'b0;
            iss_valid        <= 1'b0;
            iss_we           <= 1'b0;
            iss_draw         <= 1'b0;
            iss_addr         <= '0;
            iss_wdata        <= '0;
        end else begin
            scan_req_q <= bus.scan_req;
            if (bus.scan_req && scan_req_q) bus.scan_overrun <= 1'b1;
            if (bus.scan_req) begin
                iss_valid <= 1'b1;
                iss_we    <= 1'b0;
                iss_draw  <= 1'b0;
                iss_addr  <= bus.scan_addr;
                iss_wdata <= '0;
            end else if (pop) begin
                iss_valid <= 1'b1;
                iss_we    <= head_we;
                iss_draw  <= 1'b1;
                iss_addr  <= head_addr;
                iss_wdata <= head_wdata;
            end else begin
                iss_valid <= 1'b0;
                iss_we    <= 1'b0;
                iss_draw  <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            bus.mem_en      <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            tag1_valid      <= 1'b0;
            tag1_draw       <= 1'b0;
            tag2_valid      <= 1'b0;
            tag2_draw       <= 1'b0;
            bus.scan_valid  <= 1'b0;
            bus.scan_data   <= '0;
            bus.draw_rvalid <= 1'b0;
            bus.draw_rdata  <= '0;
        end else begin
            bus.mem_en    <= iss_valid;
            bus.mem_we    <= iss_valid && iss_we;
            bus.mem_addr  <= iss_addr;
            bus.mem_wdata <= iss_wdata;

            tag1_valid <= iss_valid && !iss_we;
            tag1_draw  <= iss_draw;
            tag2_valid <= tag1_valid;
            tag2_draw  <= tag1_draw;

            bus.scan_valid  <= tag2_valid && !tag2_draw;
            bus.draw_rvalid <= tag2_valid && tag2_draw;
            if (tag2_valid && !tag2_draw) bus.scan_data  <= bus.mem_rdata;
            if (tag2_valid && tag2_draw)  bus.draw_rdata <= bus.mem_rdata;
        end
    end

    // Busy holds through the draw_rvalid cycle and drops on the following one.
    assign bus.draw_busy = (count != '0)
                         || (iss_valid && iss_draw && !iss_we)
                         || (tag1_valid && tag1_draw)
                         || (tag2_valid && tag2_draw)
                         || bus.draw_rvalid;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - scoreboard bench for fb_arbiter with a queue-based arbitration model
module tb_fb_arbiter;
    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK100MHZ(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int            due;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_on   = 1'b0;
    bit   ov_exp   = 1'b0;
    bit   prev_scan = 1'b0;
    ent_t mq[$];
    ent_t exp_mem[$];
    ent_t exp_scan[$];
    ent_t exp_draw[$];
    logic [DW-1:0] env_ram [logic [AW-1:0]];
    logic [DW-1:0] ref_ram [logic [AW-1:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : dflt(a);
    endfunction

    // Framebuffer RAM attached to the DUT.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) env_ram[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata <= env_ram.exists(bus.mem_addr) ? env_ram[bus.mem_addr] : dflt(bus.mem_addr);
        end
    end

    // Reference model: per-edge arbitration over a command queue; expectations scheduled by edge number.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_mem.delete();
            exp_scan.delete();
            exp_draw.delete();
            ov_exp    = 1'b0;
            prev_scan = 1'b0;
        end else begin
            ent_t e;
            ent_t c;
            bit   accept;
            cyc++;
            accept = bus.draw_valid && (mq.size() < DEPTH);
            if (bus.scan_req) begin
                if (prev_scan) ov_exp = 1'b1;
                e.due = cyc + 1; e.we = 1'b0; e.addr = bus.scan_addr; e.data = '0;
                exp_mem.push_back(e);
                e.due = cyc + 3; e.data = ref_read(bus.scan_addr);
                exp_scan.push_back(e);
            end else if (mq.size() > 0) begin
                c = mq.pop_front();
                e = c;
                e.due = cyc + 1;
                exp_mem.push_back(e);
                if (c.we) begin
                    ref_ram[c.addr] = c.data;
                end else begin
                    e.due = cyc + 3; e.data = ref_read(c.addr);
                    exp_draw.push_back(e);
                end
            end
            prev_scan = bus.scan_req;
            if (accept) begin
                c.due = 0; c.we = bus.draw_we; c.addr = bus.draw_addr; c.data = bus.draw_wdata;
                mq.push_back(c);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && mon_on) begin
            ent_t e;
            chk("draw_ready", bus.draw_ready, mq.size() != DEPTH);
            chk("draw_busy", bus.draw_busy, (mq.size() != 0) || (exp_draw.size() != 0));
            chk("scan_overrun", bus.scan_overrun, ov_exp);
            if (bus.mem_en) begin
                if (exp_mem.size() == 0) chk("mem_unexpected", 1, 0);
                else begin
                    e = exp_mem.pop_front();
                    chk("mem_time", cyc, e.due);
                    chk("mem_we", bus.mem_we, e.we);
                    chk("mem_addr", bus.mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", bus.mem_wdata, e.data);
                end
            end else begin
                if (bus.mem_we) chk("mem_we_idle", bus.mem_we, 0);
                if (exp_mem.size() != 0 && exp_mem[0].due <= cyc) begin
                    chk("mem_missing", 0, 1);
                    void'(exp_mem.pop_front());
                end
            end
            if (bus.scan_valid) begin
                if (exp_scan.size() == 0) chk("scan_unexpected", 1, 0);
                else begin
                    e = exp_scan.pop_front();
                    chk("scan_time", cyc, e.due);
                    chk("scan_data", bus.scan_data, e.data);
                end
            end else if (exp_scan.size() != 0 && exp_scan[0].due <= cyc) begin
                chk("scan_missing", 0, 1);
                void'(exp_scan.pop_front());
            end
            if (bus.draw_rvalid) begin
                if (exp_draw.size() == 0) chk("draw_unexpected", 1, 0);
                else begin
                    e = exp_draw.pop_front();
                    chk("draw_time", cyc, e.due);
                    chk("draw_rdata", bus.draw_rdata, e.data);
                end
            end else if (exp_draw.size() != 0 && exp_draw[0].due <= cyc) begin
                chk("draw_missing", 0, 1);
                void'(exp_draw.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic draw_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        bus.draw_valid = 1'b1;
        bus.draw_we    = we;
        bus.draw_addr  = a;
        bus.draw_wdata = d;
        for (int i = 0; i < 200; i++) begin
            acc = bus.draw_ready;
            tick();
            if (acc) return;
        end
        chk("draw_accept_timeout", 0, 1);
    endtask

    task automatic check_reset_vals(input logic rdy);
        chk("rst_scan_valid", bus.scan_valid, 0);
        chk("rst_scan_data", bus.scan_data, 0);
        chk("rst_scan_overrun", bus.scan_overrun, 0);
        chk("rst_draw_ready", bus.draw_ready, rdy);
        chk("rst_draw_rvalid", bus.draw_rvalid, 0);
        chk("rst_draw_rdata", bus.draw_rdata, 0);
        chk("rst_draw_busy", bus.draw_busy, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        bus.scan_req   = 1'b0;
        bus.scan_addr  = '0;
        bus.draw_valid = 1'b0;
        bus.draw_we    = 1'b0;
        bus.draw_addr  = '0;
        bus.draw_wdata = '0;
        env_ram[17'h00010] = 8'hA5;
        ref_ram[17'h00010] = 8'hA5;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_vals(1'b1);
        mon_on = 1'b1;
        tick();

        // single scan fetch
        bus.scan_req  = 1'b1;
        bus.scan_addr = 17'h00010;
        tick();
        bus.scan_req = 1'b0;
        idle(6);

        // write then read-back
        draw_cmd(1'b1, 17'h12345, 8'h3C);
        draw_cmd(1'b0, 17'h12345, 8'h00);
        bus.draw_valid = 1'b0;
        idle(8);

        // two queued writes behind six back-to-back scan reads
        draw_cmd(1'b1, 17'h00200, 8'h11);
        bus.scan_req  = 1'b1;
        bus.scan_addr = 17'h00020;
        draw_cmd(1'b1, 17'h00201, 8'h22);
        bus.draw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.scan_addr = AW'(17'h00021 + i);
            tick();
        end
        bus.scan_req = 1'b0;
        idle(8);

        // fill the FIFO under scan pressure, fifth command waits for the first pop
        bus.scan_req = 1'b1;
        for (int i = 0; i < 4; i++) draw_cmd(i[0], AW'(17'h00300 + i), DW'(8'h40 + i));
        bus.draw_we = 1'b1; bus.draw_addr = 17'h00304; bus.draw_wdata = 8'h44;
        idle(3);
        bus.scan_req = 1'b0;
        draw_cmd(1'b1, 17'h00304, 8'h44);
        bus.draw_valid = 1'b0;
        idle(10);

        // push and pop on the same edge with two entries queued
        bus.scan_req = 1'b1;
        draw_cmd(1'b1, 17'h00400, 8'h51);
        draw_cmd(1'b0, 17'h00400, 8'h00);
        bus.scan_req = 1'b0;
        draw_cmd(1'b0, 17'h00401, 8'h00);
        bus.draw_valid = 1'b0;
        idle(10);

        // randomized mixed traffic over a small overlapping address window
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.draw_valid || acc) begin
                bus.draw_valid = ($urandom_range(0, 9) < 7);
                bus.draw_we    = 1'($urandom_range(0, 1));
                bus.draw_addr  = 17'h00100 + AW'($urandom_range(0, 7));
                bus.draw_wdata = DW'($urandom);
            end
            bus.scan_req  = ($urandom_range(0, 3) == 0);
            bus.scan_addr = 17'h00100 + AW'($urandom_range(0, 9));
            acc = bus.draw_valid && bus.draw_ready;
            tick();
        end
        bus.draw_valid = 1'b0;
        bus.scan_req   = 1'b0;
        idle(20);

        // asynchronous reset with three queued commands and a scan read in flight
        bus.scan_req  = 1'b1;
        bus.scan_addr = 17'h00010;
        draw_cmd(1'b1, 17'h00500, 8'h61);
        draw_cmd(1'b1, 17'h00501, 8'h62);
        draw_cmd(1'b1, 17'h00502, 8'h63);
        bus.draw_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1 check_reset_vals(1'b0);
        bus.scan_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_reset_ready", bus.draw_ready, 1);
        idle(12);

        chk("exp_mem_drained", exp_mem.size(), 0);
        chk("exp_scan_drained", exp_scan.size(), 0);
        chk("exp_draw_drained", exp_draw.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Framebuffer memory arbiter between the VGA scan-out path and the drawing engine. It shares one single-port synchronous framebuffer RAM between them. Scan-out pixel fetches have absolute priority. Draw reads and writes are buffered in a small command FIFO and issued in cycles where scan-out does not request. It sits between the VGA timing/pixel pipeline and the framebuffer RAM inside `top`, clocked from the 100 MHz board clock.

## Interface

Parameters:
- ADDR_W, 17, framebuffer word address width.
- DATA_W, 8, pixel/word width.
- FIFO_DEPTH, 4, draw command FIFO entries; must be a power of two and at least 2.

Ports:
- CLK100MHZ  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- scan_req  in  1  scan-out fetch request, single-cycle pulse per pixel.
- scan_addr  in  ADDR_W  scan-out fetch address; sampled with scan_req.
- scan_valid  out  1  scan_data valid, 1-cycle pulse.
- scan_data  out  DATA_W  fetched pixel.
- scan_overrun  out  1  sticky flag: scan_req was high on two consecutive cycles.
- draw_valid  in  1  draw command offered.
- draw_ready  out  1  FIFO can accept a command; equals (count != FIFO_DEPTH).
- draw_we  in  1  1 = write command, 0 = read command.
- draw_addr  in  ADDR_W  draw command address.
- draw_wdata  in  DATA_W  draw write data.
- draw_rvalid  out  1  draw_rdata valid, 1-cycle pulse.
- draw_rdata  out  DATA_W  draw read result.
- draw_busy  out  1  FIFO non-empty or draw access in flight.
- mem_en  out  1  RAM access enable, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_wdata  out  DATA_W  RAM write data, registered.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after an mem_en read.

## Operation

- Draw handshake: a command is accepted on a clock edge when both draw_valid and draw_ready are high. It is pushed into the FIFO as {we, addr, wdata}.
- Arbitration, evaluated on each edge:
  - If scan_req is high, the scan read is issued. mem_en=1, mem_we=0, mem_addr=scan_addr.
  - Otherwise, if the FIFO holds an entry, the head is popped and issued. mem_we=head.we.
  - Otherwise mem_en=0. mem_we is forced to 0 whenever mem_en=0.
- Push and pop may occur on the same edge. The count is then unchanged.
- A command pushed on edge N is not eligible for issue before edge N+1; there is no FIFO bypass.
- Read return tracking:
  - A 2-stage tag pipeline {valid, owner} follows every issued read.
  - At the return stage, mem_rdata is registered into scan_data or draw_rdata according to owner, and the matching valid pulse is raised.
  - Write commands produce no return.
- Ordering: draw commands are issued strictly in FIFO order. A draw read issued after a draw write to the same address returns the written data.
- scan_overrun is set when scan_req is high on two consecutive edges. Both requests are still served. The flag is cleared only by rst.
- draw_busy = (count != 0) OR (a draw-owned read is in the tag pipeline).
- Starvation: draw traffic may wait indefinitely while scan_req is held. There is no timeout; this is by design.
- Reset: asynchronous assertion clears the FIFO (count=0), the tag pipeline and all registered outputs. In-flight reads never produce a valid pulse after reset.
- Reset values: scan_valid=0, scan_data=0, scan_overrun=0, draw_ready=1 (once rst deasserts; 0 while rst high), draw_rvalid=0, draw_rdata=0, draw_busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Timing

- Scan read:
  - scan_req sampled at edge N.
  - mem_en/mem_addr driven after edge N+1.
  - RAM data arrives on mem_rdata after edge N+2.
  - scan_valid/scan_data are high for the cycle after edge N+3. Fixed latency is 3 edges.
- Draw read: issue decision at edge M gives draw_rvalid after edge M+3.
- Draw write: accepted at edge N with the FIFO empty and no scan_req gives mem_we high after edge N+2 at the earliest.
- Throughput: one RAM access per cycle. With scan_req every 4th cycle (25 MHz pixel rate), draw traffic gets 3 of every 4 cycles.
- draw_ready is combinational from count only and is independent of draw_valid.

## Test plan

- Reset: assert rst mid-sim with 3 FIFO entries and one scan read in flight. Response: all outputs reach reset values immediately, no scan_valid ever follows, and draw_ready=1 after release.
- Scan read: RAM[0x00010]=0xA5, scan_req with scan_addr=0x00010 at edge N. Response: mem_en=1, mem_addr=0x00010 after N+1; scan_valid=1, scan_data=0xA5 after N+3 for exactly 1 cycle.
- Write then read-back: draw write addr 0x12345, data 0x3C, then draw read of the same address, no scan traffic. Response: mem_we pulse with 0x3C, then draw_rvalid=1, draw_rdata=0x3C. draw_busy falls the cycle after draw_rvalid.
- Priority: queue 2 draw writes, then hold scan_req for 6 consecutive cycles. Response: 6 reads with mem_we=0 throughout and scan_overrun=1. Both writes issue on the two cycles after scan_req drops, in order.
- FIFO full: hold scan_req high and offer 5 draw commands back-to-back. Response: draw_ready drops after the 4th accept and the 5th is held. The 5th is accepted the cycle after the first pop once scan_req drops.
- Same-edge push/pop: FIFO count=2, no scan_req, one accept plus one issue on the same edge. Response: count stays 2 and the order is preserved on mem_addr.
